// File: rtl/add_n_seq.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock with a registered carry between
// slices, valid/ready handshakes on both sides and carry/overflow/zero flags.
module add_n_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]              r_state;
    logic [N-1:0][CHUNK-1:0] r_a;
    logic [N-1:0][CHUNK-1:0] r_b;
    logic [N-1:0][CHUNK-1:0] r_res;
    logic                    r_cy;
    logic [KW-1:0]           r_k;
    logic [N-1:0][CHUNK-1:0] r_out;
    logic                    r_carry;
    logic                    r_ovf;
    logic                    r_zero;

    logic [CHUNK-1:0]        w_a_sl;
    logic [CHUNK-1:0]        w_b_sl;
    logic [CHUNK:0]          w_sum;
    logic [N-1:0][CHUNK-1:0] w_full;
    logic                    w_last;
    logic                    w_ovf;

    // w_full is the working result with the current slice merged in, so the final
    // slice lands in r_out together with the flags in one edge.
    always_comb begin
        w_a_sl    = r_a[r_k];
        w_b_sl    = r_b[r_k];
        w_sum     = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{CHUNK{1'b0}}, r_cy};
        w_full    = r_res;
        w_full[r_k] = w_sum[CHUNK-1:0];
        w_last    = (r_k == K_LAST);
        w_ovf     = (r_a[N-1][CHUNK-1] == r_b[N-1][CHUNK-1]) &&
                    (w_sum[CHUNK-1] != r_a[N-1][CHUNK-1]);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cy    <= 1'b0;
            r_k     <= '0;
            r_out   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        // Subtraction is A + ~B + 1: invert B once here, seed carry with 1.
                        r_a     <= i_a;
                        r_b     <= i_sub ? ~i_b : i_b;
                        r_cy    <= i_sub;
                        r_k     <= '0;
                        r_res   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_res[r_k] <= w_sum[CHUNK-1:0];
                    r_cy       <= w_sum[CHUNK];
                    if (w_last) begin
                        r_out   <= w_full;
                        r_carry <= w_sum[CHUNK];
                        r_ovf   <= w_ovf;
                        r_zero  <= (w_full == '0);
                        r_state <= S_DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready  = (r_state == S_IDLE);
    assign o_out_valid = (r_state == S_DONE);
    assign o_out       = r_out;
    assign o_carry     = r_carry;
    assign o_overflow  = r_ovf;
    assign o_zero      = r_zero;

endmodule

// File: tb/tb_add_n_seq.sv
// Bench for add_n_seq: three configurations (16/4, 16/16, 32/8) checked with a vector
// table, directed backpressure/reset sequences and random ops against an arithmetic model.
module tb_add_n_seq;
    typedef struct {
        int          d;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] out;
        logic        c;
        logic        ov;
        logic        z;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid [3];
    logic        sub_v    [3];
    logic        out_ready[3];
    logic [31:0] a_v      [3];
    logic [31:0] b_v      [3];
    logic        in_ready [3];
    logic        out_valid[3];
    logic        c_o      [3];
    logic        ov_o     [3];
    logic        z_o      [3];
    logic [31:0] out_o    [3];
    logic [15:0] out0, out1;
    logic [31:0] out2;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    assign out_o[0] = {16'h0, out0};
    assign out_o[1] = {16'h0, out1};
    assign out_o[2] = out2;

    add_n_seq #(.WIDTH(16), .CHUNK(4)) u_d0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]),
        .i_a(a_v[0][15:0]), .i_b(b_v[0][15:0]), .i_sub(sub_v[0]),
        .o_out_valid(out_valid[0]), .i_out_ready(out_ready[0]), .o_out(out0),
        .o_carry(c_o[0]), .o_overflow(ov_o[0]), .o_zero(z_o[0]));

    add_n_seq #(.WIDTH(16), .CHUNK(16)) u_d1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]),
        .i_a(a_v[1][15:0]), .i_b(b_v[1][15:0]), .i_sub(sub_v[1]),
        .o_out_valid(out_valid[1]), .i_out_ready(out_ready[1]), .o_out(out1),
        .o_carry(c_o[1]), .o_overflow(ov_o[1]), .o_zero(z_o[1]));

    add_n_seq #(.WIDTH(32), .CHUNK(8)) u_d2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[2]), .o_in_ready(in_ready[2]),
        .i_a(a_v[2]), .i_b(b_v[2]), .i_sub(sub_v[2]),
        .o_out_valid(out_valid[2]), .i_out_ready(out_ready[2]), .o_out(out2),
        .o_carry(c_o[2]), .o_overflow(ov_o[2]), .o_zero(z_o[2]));

    function automatic int wid(input int d);
        return (d == 2) ? 32 : 16;
    endfunction

    function automatic int lat_exp(input int d);
        return (d == 1) ? 2 : 5;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: unsigned/signed arithmetic on the operand values, not slices.
    function automatic void ref_op(input int w, input logic [31:0] ta, input logic [31:0] tb_,
                                   input logic ts, output logic [31:0] r, output logic c,
                                   output logic ov, output logic z);
        longint unsigned m, ua, ub, ur;
        longint sa, sb, sr, half;
        m    = 64'd1 << w;
        half = longint'(m / 2);
        ua   = {32'h0, ta} & (m - 1);
        ub   = {32'h0, tb_} & (m - 1);
        sa   = longint'(ua);
        sb   = longint'(ub);
        if (ua >= m / 2) sa = sa - longint'(m);
        if (ub >= m / 2) sb = sb - longint'(m);
        if (ts) begin
            ur = (ua + m - ub) % m;
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            ur = (ua + ub) % m;
            c  = ((ua + ub) >= m);
            sr = sa + sb;
        end
        ov = (sr < -half) || (sr >= half);
        r  = ur[31:0];
        z  = (ur == 0);
    endfunction

    task automatic run_op(input int d, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic ts, output logic [31:0] r, output logic c,
                          output logic ov, output logic z, output int lat);
        int n;
        @(negedge clk);
        chk("in_ready_before_issue", in_ready[d], 1);
        a_v[d] = ta; b_v[d] = tb_; sub_v[d] = ts; in_valid[d] = 1'b1; out_ready[d] = 1'b1;
        @(negedge clk);
        in_valid[d] = 1'b0;
        lat = 1; n = 0;
        while (!out_valid[d] && n < 64) begin
            @(negedge clk);
            lat++; n++;
        end
        r = out_o[d]; c = c_o[d]; ov = ov_o[d]; z = z_o[d];
        @(negedge clk);
        chk("out_valid_drop", out_valid[d], 0);
    endtask

    task automatic chk_reset(input int d);
        chk("rst_in_ready", in_ready[d], 1);
        chk("rst_out_valid", out_valid[d], 0);
        chk("rst_out", out_o[d], 0);
        chk("rst_carry", c_o[d], 0);
        chk("rst_overflow", ov_o[d], 0);
        chk("rst_zero", z_o[d], 0);
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] m, v;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        v = $urandom;
        case ($urandom_range(0, 7))
            0: v = 32'h0;
            1: v = m;
            2: v = m >> 1;
            3: v = (m >> 1) + 32'h1;
            default: ;
        endcase
        return v & m;
    endfunction

    task automatic add_vec(inout vec_t q[$], input int d, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] o, input logic c, input logic ov,
                           input logic z);
        vec_t v;
        v.d = d; v.a = a; v.b = b; v.sub = s; v.out = o; v.c = c; v.ov = ov; v.z = z;
        q.push_back(v);
    endtask

    initial begin
        vec_t        tbl[$];
        logic [31:0] r, er, ta, tb_;
        logic        c, ov, z, ec, eov, ez, ts;
        int          lat, n;

        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0; sub_v[d] = 1'b0; out_ready[d] = 1'b0;
            a_v[d] = 32'h0; b_v[d] = 32'h0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) chk_reset(d);
        rst_n = 1'b1;

        add_vec(tbl, 0, 32'h1234, 32'h0001, 1'b0, 32'h1235, 1'b0, 1'b0, 1'b0);
        add_vec(tbl, 0, 32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b0, 1'b1);
        add_vec(tbl, 0, 32'h7FFF, 32'h0001, 1'b0, 32'h8000, 1'b0, 1'b1, 1'b0);
        add_vec(tbl, 0, 32'h0005, 32'h0007, 1'b1, 32'hFFFE, 1'b0, 1'b0, 1'b0);
        add_vec(tbl, 0, 32'h8000, 32'h0001, 1'b1, 32'h7FFF, 1'b1, 1'b1, 1'b0);
        add_vec(tbl, 1, 32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b0, 1'b1);
        add_vec(tbl, 1, 32'h7FFF, 32'h0001, 1'b0, 32'h8000, 1'b0, 1'b1, 1'b0);
        add_vec(tbl, 2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        add_vec(tbl, 2, 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        add_vec(tbl, 2, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        foreach (tbl[i]) begin
            run_op(tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].sub, r, c, ov, z, lat);
            chk($sformatf("vec%0d_out", i), r, tbl[i].out);
            chk($sformatf("vec%0d_carry", i), c, tbl[i].c);
            chk($sformatf("vec%0d_overflow", i), ov, tbl[i].ov);
            chk($sformatf("vec%0d_zero", i), z, tbl[i].z);
            chk($sformatf("vec%0d_latency", i), lat, lat_exp(tbl[i].d));
        end

        // Backpressure: result held for 3 cycles while new operands are offered.
        @(negedge clk);
        a_v[0] = 32'h00F0; b_v[0] = 32'h000F; sub_v[0] = 1'b0;
        in_valid[0] = 1'b1; out_ready[0] = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b0;
        n = 0;
        while (!out_valid[0] && n < 64) begin @(negedge clk); n++; end
        for (int i = 0; i < 4; i++) begin
            chk("bp_out_valid", out_valid[0], 1);
            chk("bp_in_ready", in_ready[0], 0);
            chk("bp_out", out_o[0], 32'h00FF);
            chk("bp_flags", {c_o[0], ov_o[0], z_o[0]}, 3'b000);
            a_v[0] = 32'hAAAA; b_v[0] = 32'h5555; sub_v[0] = 1'b1; in_valid[0] = (i < 3);
            if (i < 3) @(negedge clk);
        end
        in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", in_ready[0], 1);
        chk("bp_release_out_valid", out_valid[0], 0);
        chk("bp_release_out_kept", out_o[0], 32'h00FF);
        @(negedge clk);
        chk("bp_ignored_still_idle", in_ready[0], 1);

        // Reset during RUN at slice k=2 discards the operation.
        a_v[0] = 32'h1234; b_v[0] = 32'h1111; sub_v[0] = 1'b0; in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_reset(0);
        repeat (4) @(negedge clk);
        chk("abort_no_result", out_valid[0], 0);
        run_op(0, 32'h0003, 32'h0004, 1'b0, r, c, ov, z, lat);
        chk("post_reset_out", r, 32'h0007);
        chk("post_reset_latency", lat, 5);

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 200; i++) begin
                ta = pick(wid(d)); tb_ = pick(wid(d)); ts = 1'($urandom_range(0, 1));
                run_op(d, ta, tb_, ts, r, c, ov, z, lat);
                ref_op(wid(d), ta, tb_, ts, er, ec, eov, ez);
                chk($sformatf("rnd_d%0d_%0d_out", d, i), r, er);
                chk($sformatf("rnd_d%0d_%0d_flags", d, i), {c, ov, z}, {ec, eov, ez});
                chk($sformatf("rnd_d%0d_%0d_latency", d, i), lat, lat_exp(d));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/add_n_seq.md
# add_n_seq

Parametrised multi-cycle adder/subtractor. It adds or subtracts two WIDTH-bit operands in CHUNK-bit slices, one slice per clock, and keeps the carry in a register between slices. It replaces the fixed 16-bit combinational ripple adder wherever a narrower carry chain, a valid/ready handshake and status flags (carry, overflow, zero) are needed. It sits between the ALU operand registers and the result bus.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK
- CHUNK, 4, bits added per cycle; N = WIDTH/CHUNK cycles per operation; CHUNK = WIDTH gives N = 1
- clk  input  1  single clock, rising-edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operands and mode are valid this cycle
- in_ready  output  1  block can accept an operation (high only in IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0: A+B; 1: A-B (B is inverted, carry-in is 1)
- out_valid  output  1  result and flags are valid
- out_ready  input  1  consumer accepts the result
- out  output  WIDTH  sum or difference, modulo 2^WIDTH
- carry  output  1  carry out of the MSB; for subtraction, 1 means no borrow (A >= B unsigned)
- overflow  output  1  signed two's-complement overflow
- zero  output  1  out == 0

## Operation
- There is one clock and one reset. Reset is synchronous and active-low: rst_n is sampled on the rising edge of clk.
- The state machine has three states: IDLE, RUN and DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid && in_ready:
    - latch a into an internal A register;
    - latch b, or ~b when sub = 1, into an internal B register;
    - load the carry register with sub;
    - clear the slice counter k;
    - go to RUN.
- **RUN**
  - Each cycle computes {c, s} = A[k*CHUNK +: CHUNK] + B[k*CHUNK +: CHUNK] + carry_reg.
  - s is written to result[k*CHUNK +: CHUNK] and c to carry_reg, then k increments.
  - When k = N-1:
    - overflow = (A[MSB] == B[MSB]) && (s[MSB] != A[MSB]), using the latched (inverted) B;
    - carry = c;
    - zero is evaluated on the complete result;
    - go to DONE.
- **DONE**
  - out_valid = 1; out and the flags are stable.
  - On out_ready: go to IDLE.
  - in_ready = 0, so a new operation cannot be accepted in the same cycle as the result is consumed.
- in_valid while not in IDLE is ignored. a, b and sub are not sampled.
- out and the flags keep their last values after the result is consumed, until the next operation completes. They must not show partial slices while out_valid = 1.
- Reset values: in_ready = 1 (IDLE), out_valid = 0, out = 0, carry = 0, overflow = 0, zero = 0. Internal registers are 0.
- rst_n low in any state, including mid-RUN and DONE, aborts the operation. The next cycle is IDLE with all reset values, and the partial result is discarded.

## Timing
- The accept handshake happens in cycle t.
- RUN occupies cycles t+1 … t+N.
- out_valid first goes high in cycle t+N+1.
- Latency from accept to result is N+1 cycles; for defaults (N = 4) that is 5.
- in_ready returns to 1 in the cycle after the out_valid && out_ready handshake.
- The minimum issue interval is N+2 cycles.
- The carry path is CHUNK bits per cycle; there is no combinational path from inputs to outputs.
- in_ready and out_valid are driven from registers or state decode only.

## Test plan
- **Basic add** (WIDTH=16, CHUNK=4): a=0x1234, b=0x0001, sub=0, out_ready=1.
  - out=0x1235, carry=0, overflow=0, zero=0.
  - out_valid is high exactly 5 cycles after accept and drops the following cycle.
- **Wrap-around**: 0xFFFF + 0x0001 → out=0x0000, carry=1, zero=1, overflow=0. Then 0x7FFF + 0x0001 → out=0x8000, carry=0, overflow=1.
- **Subtract with borrow**: sub=1.
  - 0x0005 − 0x0007 → out=0xFFFE, carry=0, overflow=0.
  - 0x8000 − 0x0001 → out=0x7FFF, carry=1, overflow=1.
- **Backpressure**: hold out_ready=0 for 3 cycles in DONE and pulse in_valid with new operands.
  - out, flags and out_valid are stable; in_ready=0; the new operands are ignored.
  - After out_ready=1, in_ready=1 on the next cycle.
- **Reset mid-operation**: drive rst_n=0 for one cycle during RUN (k=2).
  - The next cycle shows IDLE with in_ready=1, out_valid=0, out=0 and all flags 0.
  - A following 0x0003+0x0004 gives 0x0007.
- **Parameter sweep**: CHUNK=16 (N=1, latency 2) and WIDTH=32/CHUNK=8 (latency 5).
  - 0xFFFFFFFF + 0x00000001 → out=0, carry=1, zero=1.
  - 200 random operations are checked against a reference model for both configurations.
